// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Instruction phase sequencer and program counter for the ForthCPU core.
//   Steps IDLE -> FETCH -> DECODE -> EXECUTE -> COMMIT -> FETCH ... and
//   drives one-hot phase strobes to the group decoders. The jump decision
//   is taken at the EXECUTE edge. The PC is updated at the COMMIT edge from
//   the jump-group controls. A HALT instruction (PC_EN=0) parks the core
//   until RESET.
//
// Parameters
//   RESET_VECTOR  PC value loaded on reset
//
// Ports
//   CLK, RESET                     clock, synchronous active-high reset
//   RUN                            start enable, sampled only in IDLE
//   MEM_WAIT                       stretches FETCH while instruction memory is busy
//   PC_EN                          0 = current instruction is HALT
//   JMPX, JRX                      jump op / relative (1) or absolute (0)
//   CC_APPLYX, CC_INVERTX          conditional jump / take jump when flag is 0
//   CC_SELECTX                     flag select: 00 Z, 01 C, 10 N, 11 V
//   CC_Z, CC_C, CC_N, CC_V         ALU flags
//   JUMP_TARGET                    absolute address or signed relative offset
//   FETCH, DECODE, EXECUTE, COMMIT registered one-hot phase strobes
//   PC                             registered program counter
//   LINK_ADDR                      PC+1, the return address
//   TAKEN                          registered jump decision, valid in COMMIT
//   HALTED                         core stopped by HALT
module pc_sequencer #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        RUN,
    input  logic        MEM_WAIT,
    input  logic        PC_EN,
    input  logic        JMPX,
    input  logic        JRX,
    input  logic        CC_APPLYX,
    input  logic        CC_INVERTX,
    input  logic [1:0]  CC_SELECTX,
    input  logic        CC_Z,
    input  logic        CC_C,
    input  logic        CC_N,
    input  logic        CC_V,
    input  logic [15:0] JUMP_TARGET,
    output logic        FETCH,
    output logic        DECODE,
    output logic        EXECUTE,
    output logic        COMMIT,
    output logic [15:0] PC,
    output logic [15:0] LINK_ADDR,
    output logic        TAKEN,
    output logic        HALTED
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_COMMIT,
        S_HALT
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        flag_sel;
    logic        taken_next;
    logic        jr_q;
    logic [15:0] pc_next;

    always_comb begin
        flag_sel = CC_Z;
        case (CC_SELECTX)
            2'b00:   flag_sel = CC_Z;
            2'b01:   flag_sel = CC_C;
            2'b10:   flag_sel = CC_N;
            default: flag_sel = CC_V;
        endcase
    end

    assign taken_next = JMPX & (~CC_APPLYX | (flag_sel ^ CC_INVERTX));
    assign LINK_ADDR  = PC + 16'd1;

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (RUN) next_state = S_FETCH;
            S_FETCH:   if (!MEM_WAIT) next_state = S_DECODE;
            S_DECODE:  next_state = S_EXECUTE;
            S_EXECUTE: next_state = S_COMMIT;
            S_COMMIT:  next_state = PC_EN ? S_FETCH : S_HALT;
            S_HALT:    next_state = S_HALT;
            default:   next_state = S_IDLE;
        endcase
    end

    // JRX is captured with the decision at EXECUTE so the addressing mode
    // matches the flags that produced TAKEN. HALT beats a taken jump.
    always_comb begin
        pc_next = PC;
        if (state == S_COMMIT && PC_EN) begin
            if (TAKEN)
                pc_next = jr_q ? (LINK_ADDR + JUMP_TARGET) : JUMP_TARGET;
            else
                pc_next = LINK_ADDR;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= S_IDLE;
            FETCH   <= 1'b0;
            DECODE  <= 1'b0;
            EXECUTE <= 1'b0;
            COMMIT  <= 1'b0;
            TAKEN   <= 1'b0;
            HALTED  <= 1'b0;
            jr_q    <= 1'b0;
            PC      <= RESET_VECTOR;
        end else begin
            state   <= next_state;
            // Strobes decode the next state, so each one is high exactly
            // while the sequencer sits in the matching phase.
            FETCH   <= (next_state == S_FETCH);
            DECODE  <= (next_state == S_DECODE);
            EXECUTE <= (next_state == S_EXECUTE);
            COMMIT  <= (next_state == S_COMMIT);
            TAKEN   <= (state == S_EXECUTE) ? taken_next : 1'b0;
            if (state == S_EXECUTE)
                jr_q <= JRX;
            PC      <= pc_next;
            if (state == S_COMMIT && !PC_EN)
                HALTED <= 1'b1;
        end
    end

endmodule
